// File: rtl/video_pixel_bridge_if.sv
// Pixel stream bundle between a decoder-style source, the bridge and a plot sink.
// Handshake: a beat transfers on a rising edge where valid (in_valid / out_plot) and ready (in_ready / out_ready) are both 1; the source holds its payload stable while ready is 0.
interface video_pixel_bridge_if #(
  parameter int BITS_PER_COLOUR_CHANNEL = 1
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [8:0]                           in_x;
  logic [7:0]                           in_y;
  logic [4:0]                           in_red;
  logic [5:0]                           in_green;
  logic [4:0]                           in_blue;
  logic                                 out_plot;
  logic                                 out_ready;
  logic [8:0]                           out_x;
  logic [7:0]                           out_y;
  logic [3*BITS_PER_COLOUR_CHANNEL-1:0] out_colour;

  modport master (
    output in_valid, in_x, in_y, in_red, in_green, in_blue, out_ready,
    input  in_ready, out_plot, out_x, out_y, out_colour
  );

  modport slave (
    input  in_valid, in_x, in_y, in_red, in_green, in_blue, out_ready,
    output in_ready, out_plot, out_x, out_y, out_colour
  );
endinterface

// File: rtl/video_pixel_bridge.sv
// RGB565 pixel stream to low-depth VGA colour: optional 2x decimation, colour reduction,
// then a FIFO whose head sits in a registered output stage.
module video_pixel_bridge #(
  parameter int         BITS_PER_COLOUR_CHANNEL = 1,
  parameter int         MODE                    = 0,
  parameter int         FIFO_DEPTH              = 8,
  parameter int         DECIMATE                = 0,
  parameter logic [7:0] MONO_THRESHOLD          = 8'd94
) (
  input  logic                          clock,
  input  logic                          resetn,
  video_pixel_bridge_if.slave           pix,
  output logic                          frame_start,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int B  = BITS_PER_COLOUR_CHANNEL;
  localparam int CW = 3 * B;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 9 + 8 + CW;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  function automatic logic [B-1:0] round_sat(input logic [B-1:0] t, input logic n);
    logic [B:0] s;
    s = {1'b0, t} + {{B{1'b0}}, n};
    return s[B] ? {B{1'b1}} : s[B-1:0];
  endfunction

  logic [B-1:0]  r_t, g_t, b_t;
  logic          r_n, g_n, b_n;
  logic [7:0]    luma;
  logic [CW-1:0] colour;

  assign r_t  = pix.in_red[4 -: B];
  assign g_t  = pix.in_green[5 -: B];
  assign b_t  = pix.in_blue[4 -: B];
  // At full 5-bit width red/blue have no lower bit left to round with.
  assign r_n  = (B < 5) ? pix.in_red[(B < 5) ? 4 - B : 0] : 1'b0;
  assign b_n  = (B < 5) ? pix.in_blue[(B < 5) ? 4 - B : 0] : 1'b0;
  assign g_n  = pix.in_green[5 - B];
  assign luma = {2'b00, pix.in_red, 1'b0} + {2'b00, pix.in_green} + {2'b00, pix.in_blue, 1'b0};

  always_comb begin
    colour = {r_t, g_t, b_t};
    if (MODE == 1) begin
      colour = {round_sat(r_t, r_n), round_sat(g_t, g_n), round_sat(b_t, b_n)};
    end else if (MODE == 2) begin
      colour = {CW{luma >= MONO_THRESHOLD}};
    end
  end

  logic       keep;
  logic [8:0] dx;
  logic [7:0] dy;

  assign keep = (DECIMATE == 0) || (!pix.in_x[0] && !pix.in_y[0]);
  assign dx   = (DECIMATE == 0) ? pix.in_x : {1'b0, pix.in_x[8:1]};
  assign dy   = (DECIMATE == 0) ? pix.in_y : {1'b0, pix.in_y[7:1]};

  // level counts the memory entries plus the one held in the output stage.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] mem_count, level_next;
  logic          accept, push, pop, load;

  assign accept     = pix.in_valid && pix.in_ready;
  assign push       = accept && keep;
  assign pop        = pix.out_plot && pix.out_ready;
  assign mem_count  = level - LW'(pix.out_plot);
  assign load       = (mem_count != '0) && (!pix.out_plot || pop);
  assign level_next = level + LW'(push) - LW'(pop);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {dx, dy, colour};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      frame_start    <= 1'b0;
      pix.in_ready   <= 1'b0;
      pix.out_plot   <= 1'b0;
      pix.out_x      <= '0;
      pix.out_y      <= '0;
      pix.out_colour <= '0;
    end else begin
      level        <= level_next;
      pix.in_ready <= (level_next < DEPTH_L);
      frame_start  <= accept && (pix.in_x == 9'd0) && (pix.in_y == 8'd0);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        rd_ptr                                  <= rd_ptr + AW'(1);
        {pix.out_x, pix.out_y, pix.out_colour}  <= mem[rd_ptr];
        pix.out_plot                            <= 1'b1;
      end else if (pop) begin
        pix.out_plot <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_video_pixel_bridge.sv
// Bench for video_pixel_bridge: three configurations share one input stream;
// each output is scoreboarded against a bench-side colour/decimation model.
module tb_video_pixel_bridge;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic [4:0] in_red = '0;
  logic [5:0] in_green = '0;
  logic [4:0] in_blue = '0;
  logic       rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  logic       rand_rdy = 1'b0;
  logic [2:0] lvl0;
  logic [3:0] lvl1, lvl2;
  logic       fs0, fs1, fs2;

  int n_checks = 0;
  int n_pass = 0;
  int out_cnt0 = 0, out_cnt1 = 0, out_cnt2 = 0;
  int fs_cnt0 = 0, fs_cnt1 = 0, fs_cnt2 = 0;

  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];

  video_pixel_bridge_if #(.BITS_PER_COLOUR_CHANNEL(1)) if0 ();
  video_pixel_bridge_if #(.BITS_PER_COLOUR_CHANNEL(2)) if1 ();
  video_pixel_bridge_if #(.BITS_PER_COLOUR_CHANNEL(3)) if2 ();

  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
  assign if0.in_x = in_x;         assign if1.in_x = in_x;         assign if2.in_x = in_x;
  assign if0.in_y = in_y;         assign if1.in_y = in_y;         assign if2.in_y = in_y;
  assign if0.in_red = in_red;     assign if1.in_red = in_red;     assign if2.in_red = in_red;
  assign if0.in_green = in_green; assign if1.in_green = in_green; assign if2.in_green = in_green;
  assign if0.in_blue = in_blue;   assign if1.in_blue = in_blue;   assign if2.in_blue = in_blue;
  assign if0.out_ready = rdy0;    assign if1.out_ready = rdy1;    assign if2.out_ready = rdy2;

  video_pixel_bridge #(.BITS_PER_COLOUR_CHANNEL(1), .MODE(0), .FIFO_DEPTH(4), .DECIMATE(0)) u0 (
    .clock(clock), .resetn(resetn), .pix(if0), .frame_start(fs0), .level(lvl0));
  video_pixel_bridge #(.BITS_PER_COLOUR_CHANNEL(2), .MODE(1), .FIFO_DEPTH(8), .DECIMATE(1)) u1 (
    .clock(clock), .resetn(resetn), .pix(if1), .frame_start(fs1), .level(lvl1));
  video_pixel_bridge #(.BITS_PER_COLOUR_CHANNEL(3), .MODE(2), .FIFO_DEPTH(8), .DECIMATE(0)) u2 (
    .clock(clock), .resetn(resetn), .pix(if2), .frame_start(fs2), .level(lvl2));

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // reference model
  function automatic int chan(input int mode, input int bits, input int v, input int w);
    int t, n;
    t = v >> (w - bits);
    n = (w - bits >= 1) ? ((v >> (w - bits - 1)) & 1) : 0;
    if (mode == 1) begin
      t = t + n;
      if (t > (1 << bits) - 1) t = (1 << bits) - 1;
    end
    return t;
  endfunction

  function automatic logic [31:0] model(input int mode, input int bits, input int dec,
                                        input logic [8:0] x, input logic [7:0] y,
                                        input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
    int col, luma;
    logic [8:0] ox;
    logic [7:0] oy;
    if (mode == 2) begin
      luma = 2 * int'(r) + int'(g) + 2 * int'(b);
      col  = (luma >= 94) ? (1 << (3 * bits)) - 1 : 0;
    end else begin
      col = (chan(mode, bits, r, 5) << (2 * bits)) | (chan(mode, bits, g, 6) << bits) | chan(mode, bits, b, 5);
    end
    ox = (dec != 0) ? (x >> 1) : x;
    oy = (dec != 0) ? (y >> 1) : y;
    return {ox, oy, 15'(col)};
  endfunction

  // driver tasks
  task automatic push(input logic [8:0] x, input logic [7:0] y,
                      input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
    int cnt = 0;
    while (!(if0.in_ready && if1.in_ready && if2.in_ready) && cnt < 200) begin
      @(posedge clock); #1; cnt++;
    end
    check("push_wait_bound", cnt < 200, 1);
    in_x = x; in_y = y; in_red = r; in_green = g; in_blue = b; in_valid = 1'b1;
    @(posedge clock);
    exp0_q.push_back(model(0, 1, 0, x, y, r, g, b));
    if (!x[0] && !y[0]) exp1_q.push_back(model(1, 2, 1, x, y, r, g, b));
    exp2_q.push_back(model(2, 3, 0, x, y, r, g, b));
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt = 0;
    rand_rdy = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    while ((exp0_q.size() + exp1_q.size() + exp2_q.size()) != 0 && cnt < 400) begin
      @(posedge clock); #1; cnt++;
    end
    check("drain_bound", cnt < 400, 1);
    @(posedge clock); #1;
  endtask

  always @(posedge clock) begin
    #1;
    if (rand_rdy) begin
      rdy0 = 1'($urandom_range(0, 1));
      rdy1 = 1'($urandom_range(0, 1));
      rdy2 = 1'($urandom_range(0, 1));
    end
  end

  // scoreboard monitors
  always @(negedge clock) begin
    if (resetn && if0.out_plot && rdy0) begin
      out_cnt0++;
      check("u0_expected_avail", exp0_q.size() != 0, 1);
      if (exp0_q.size() != 0) check("u0_pixel", {if0.out_x, if0.out_y, 12'b0, if0.out_colour}, exp0_q.pop_front());
    end
    if (resetn && if1.out_plot && rdy1) begin
      out_cnt1++;
      check("u1_expected_avail", exp1_q.size() != 0, 1);
      if (exp1_q.size() != 0) check("u1_pixel", {if1.out_x, if1.out_y, 9'b0, if1.out_colour}, exp1_q.pop_front());
    end
    if (resetn && if2.out_plot && rdy2) begin
      out_cnt2++;
      check("u2_expected_avail", exp2_q.size() != 0, 1);
      if (exp2_q.size() != 0) check("u2_pixel", {if2.out_x, if2.out_y, 6'b0, if2.out_colour}, exp2_q.pop_front());
    end
    if (resetn && fs0) fs_cnt0++;
    if (resetn && fs1) fs_cnt1++;
    if (resetn && fs2) fs_cnt2++;
  end

  initial begin
    int c1;
    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_plot", {if0.out_plot, if1.out_plot, if2.out_plot}, 0);
    check("rst_in_ready", {if0.in_ready, if1.in_ready, if2.in_ready}, 0);
    check("rst_level", {lvl0, lvl1, lvl2}, 0);
    check("rst_frame_start", {fs0, fs1, fs2}, 0);
    check("rst_out_u0", {if0.out_x, if0.out_y, if0.out_colour}, 0);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("in_ready_after_release", {if0.in_ready, if1.in_ready, if2.in_ready}, 3'b111);

    // truncate, B=1, single pixel latency
    push(9'd3, 8'd2, 5'h10, 6'h1F, 5'h0F);
    check("latency_not_comb", if0.out_plot, 0);
    @(posedge clock); #1;
    check("latency_plot", if0.out_plot, 1);
    check("trunc_colour", if0.out_colour, 3'b100);
    check("trunc_x", if0.out_x, 9'd3);
    check("trunc_y", if0.out_y, 8'd2);
    drain();

    // round-saturate, B=2
    push(9'd4, 8'd6, 5'h07, 6'h17, 5'h0C);
    @(posedge clock); #1;
    check("round_red_07", if1.out_colour[5:4], 2'b01);
    drain();
    push(9'd6, 8'd6, 5'h1F, 6'h00, 5'h00);
    @(posedge clock); #1;
    check("round_red_sat", if1.out_colour[5:4], 2'b11);
    drain();

    // monochrome threshold
    push(9'd10, 8'd20, 5'd0, 6'd0, 5'd0);
    @(posedge clock); #1;
    check("mono_black", if2.out_colour, 9'h000);
    drain();
    push(9'd12, 8'd20, 5'd31, 6'd63, 5'd31);
    @(posedge clock); #1;
    check("mono_luma187", if2.out_colour, 9'h1FF);
    drain();
    push(9'd14, 8'd20, 5'd0, 6'd62, 5'd16);
    @(posedge clock); #1;
    check("mono_luma94", if2.out_colour, 9'h1FF);
    drain();

    // fill depth-4 FIFO, single pop, order, simultaneous push/pop
    rdy0 = 1'b0;
    push(9'd20, 8'd2, 5'h10, 6'h00, 5'h00);
    push(9'd22, 8'd2, 5'h00, 6'h20, 5'h00);
    push(9'd24, 8'd4, 5'h00, 6'h00, 5'h10);
    push(9'd26, 8'd4, 5'h1F, 6'h3F, 5'h1F);
    check("full_level", lvl0, 3'd4);
    check("full_in_ready", if0.in_ready, 0);
    @(posedge clock); #1;
    check("full_hold_level", lvl0, 3'd4);
    rdy0 = 1'b1;
    @(posedge clock); #1;
    rdy0 = 1'b0;
    check("pop_one_level", lvl0, 3'd3);
    check("pop_one_in_ready", if0.in_ready, 1);
    rdy0 = 1'b1;
    push(9'd28, 8'd6, 5'h10, 6'h20, 5'h10);
    check("push_pop_level", lvl0, 3'd3);
    drain();
    check("no_frame_yet", fs_cnt0 + fs_cnt1 + fs_cnt2, 0);

    // decimation on a 4x2 burst
    c1 = out_cnt1;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        push(9'(x), 8'(y), 5'(x * 7 + 3), 6'(y * 20 + x * 9), 5'(31 - x * 5));
    drain();
    check("decim_out_count", out_cnt1 - c1, 2);
    check("frame_start_u0", fs_cnt0, 1);
    check("frame_start_u1", fs_cnt1, 1);
    check("frame_start_u2", fs_cnt2, 1);

    // random traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++)
      push(9'($urandom_range(1, 319)), 8'($urandom_range(0, 239)),
           5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
    drain();
    check("q_empty_after_random", exp0_q.size() + exp1_q.size() + exp2_q.size(), 0);

    // reset mid-frame with three buffered pixels
    rdy0 = 1'b0;
    push(9'd40, 8'd10, 5'h1F, 6'h00, 5'h00);
    push(9'd42, 8'd10, 5'h00, 6'h3F, 5'h00);
    push(9'd44, 8'd10, 5'h00, 6'h00, 5'h1F);
    @(posedge clock); #1;
    check("pre_reset_level", lvl0, 3'd3);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_plot", if0.out_plot, 0);
    check("async_reset_level", lvl0, 0);
    check("async_reset_in_ready", if0.in_ready, 0);
    exp0_q.delete(); exp1_q.delete(); exp2_q.delete();
    c1 = out_cnt0 + out_cnt1 + out_cnt2;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("no_stale_outputs", out_cnt0 + out_cnt1 + out_cnt2 - c1, 0);
    check("no_stale_plot", {if0.out_plot, if1.out_plot, if2.out_plot}, 0);
    check("post_reset_level", {lvl0, lvl1, lvl2}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
